// File: rtl/symbol_iterator_if.sv
// Bundles the edit (front end) and symbol-read (plotting logic) sides of the
// expression buffer. The client drives the master modport and the buffer implements slave.
interface symbol_iterator_if #(
    parameter int SYMBOL_WIDTH = 7,
    parameter int BUFFER_SIZE  = 64,
    parameter int LENGTH_WIDTH = $clog2(BUFFER_SIZE + 1)
);
    logic [SYMBOL_WIDTH-1:0] edit_char;
    logic                    edit_push;
    logic                    edit_backspace;
    logic                    edit_clear;
    logic                    edit_ready;
    logic [LENGTH_WIDTH-1:0] length;
    logic                    symbol_iter_en;
    logic [SYMBOL_WIDTH-1:0] symbol;
    logic                    symbol_valid;

    modport master (
        output edit_char, edit_push, edit_backspace, edit_clear, symbol_iter_en,
        input  edit_ready, length, symbol, symbol_valid
    );

    modport slave (
        input  edit_char, edit_push, edit_backspace, edit_clear, symbol_iter_en,
        output edit_ready, length, symbol, symbol_valid
    );
endinterface

// File: rtl/symbol_iterator.sv
// Stores the user's function expression and streams it, NUL-terminated, one
// symbol per requested cycle. Edits are locked out while a pass is in flight.
module symbol_iterator #(
    parameter int SYMBOL_WIDTH = 7,
    parameter int BUFFER_SIZE  = 64,
    parameter int LENGTH_WIDTH = $clog2(BUFFER_SIZE + 1)
) (
    input  logic               clk,
    input  logic               rst,
    symbol_iterator_if.slave   bus
);
    localparam int IDX_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

    localparam logic [LENGTH_WIDTH-1:0] LEN_ZERO = {LENGTH_WIDTH{1'b0}};
    localparam logic [LENGTH_WIDTH-1:0] LEN_ONE  = {{(LENGTH_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LENGTH_WIDTH-1:0] LEN_FULL = LENGTH_WIDTH'(BUFFER_SIZE);
    localparam logic [SYMBOL_WIDTH-1:0] NUL_SYM  = {SYMBOL_WIDTH{1'b0}};

    logic [SYMBOL_WIDTH-1:0] mem_q [BUFFER_SIZE];

    logic [LENGTH_WIDTH-1:0] length_q, length_d;
    logic [LENGTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [SYMBOL_WIDTH-1:0] symbol_q, symbol_d;
    logic                    symbol_valid_q, symbol_valid_d;

    logic                    edit_ready_s;
    logic                    mem_we_s;
    logic [IDX_W-1:0]        wr_idx_s;
    logic [IDX_W-1:0]        rd_idx_s;

    // Index truncation is safe: both indices are only used while below BUFFER_SIZE.
    assign wr_idx_s = length_q[IDX_W-1:0];
    assign rd_idx_s = rd_ptr_q[IDX_W-1:0];

    assign edit_ready_s = (rd_ptr_q == LEN_ZERO) & ~bus.symbol_iter_en;

    // Edit decode: clear beats backspace beats push; NUL pushes and overflow are ignored.
    always_comb begin
        length_d = length_q;
        mem_we_s = 1'b0;
        if (edit_ready_s) begin
            if (bus.edit_clear) begin
                length_d = LEN_ZERO;
            end else if (bus.edit_backspace) begin
                if (length_q != LEN_ZERO) begin
                    length_d = length_q - LEN_ONE;
                end else begin
                    length_d = length_q;
                end
            end else if (bus.edit_push) begin
                if ((length_q < LEN_FULL) && (bus.edit_char != NUL_SYM)) begin
                    mem_we_s = 1'b1;
                    length_d = length_q + LEN_ONE;
                end else begin
                    mem_we_s = 1'b0;
                end
            end else begin
                length_d = length_q;
            end
        end else begin
            length_d = length_q;
        end
    end

    // Read side: emit stored symbol or the NUL terminator that wraps the pass.
    always_comb begin
        rd_ptr_d       = rd_ptr_q;
        symbol_d       = symbol_q;
        symbol_valid_d = 1'b0;
        if (bus.symbol_iter_en) begin
            symbol_valid_d = 1'b1;
            if (rd_ptr_q < length_q) begin
                symbol_d = mem_q[rd_idx_s];
                rd_ptr_d = rd_ptr_q + LEN_ONE;
            end else begin
                symbol_d = NUL_SYM;
                rd_ptr_d = LEN_ZERO;
            end
        end else begin
            symbol_valid_d = 1'b0;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            length_q       <= LEN_ZERO;
            rd_ptr_q       <= LEN_ZERO;
            symbol_q       <= NUL_SYM;
            symbol_valid_q <= 1'b0;
        end else begin
            length_q       <= length_d;
            rd_ptr_q       <= rd_ptr_d;
            symbol_q       <= symbol_d;
            symbol_valid_q <= symbol_valid_d;
        end
    end

    // Symbol storage; contents are meaningless above length so no reset is needed.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wr_idx_s] <= bus.edit_char;
        end
    end

    assign bus.edit_ready   = edit_ready_s;
    assign bus.length       = length_q;
    assign bus.symbol       = symbol_q;
    assign bus.symbol_valid = symbol_valid_q;
endmodule

// File: doc/symbol_iterator.md
Name: symbol_iterator

Overview:
- Holds the function expression typed by the user as a string of 7-bit ASCII symbols.
- Streams the expression to the plotting `logic` block over the symbol_iter_en / symbol / symbol_valid interface, one symbol per enabled cycle, terminated by NUL (0).
- Sits between the keyboard/edit front end (write side) and `logic` (read side). It is the producer end of the symbol interface that `logic` consumes.

Parameters:
- SYMBOL_WIDTH, 7, width of one ASCII symbol.
- BUFFER_SIZE, 64, maximum stored symbols, excluding the terminator.
- LENGTH_WIDTH, $clog2(BUFFER_SIZE + 1), width of length and read pointer.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- edit_char  input  SYMBOL_WIDTH  symbol to append on edit_push.
- edit_push  input  1  append edit_char (single-cycle command).
- edit_backspace  input  1  remove last symbol.
- edit_clear  input  1  empty the buffer.
- edit_ready  output  1  combinational; edit commands are accepted only in cycles where this is high.
- length  output  LENGTH_WIDTH  current number of stored symbols (registered).
- symbol_iter_en  input  1  `logic` requests the next symbol this cycle.
- symbol  output  SYMBOL_WIDTH  current symbol (registered).
- symbol_valid  output  1  symbol is valid this cycle (registered, 1-cycle pulse per request).

Behaviour:
- Storage: BUFFER_SIZE x SYMBOL_WIDTH array mem. Registers: length and read pointer rd_ptr, both LENGTH_WIDTH wide.
- Reset values: symbol=0, symbol_valid=0, length=0, rd_ptr=0. mem contents are don't-care.
- Reset mid-pass: the pass is aborted and the next request starts a fresh pass at index 0.
- Read side, evaluated every cycle:
  - If symbol_iter_en=1 and rd_ptr<length: symbol<=mem[rd_ptr], symbol_valid<=1, rd_ptr<=rd_ptr+1.
  - If symbol_iter_en=1 and rd_ptr==length: symbol<=0 (NUL), symbol_valid<=1, rd_ptr<=0 (pass complete, wraps).
  - If symbol_iter_en=0: symbol_valid<=0, symbol holds its last value, rd_ptr unchanged.
- Latency: a request in cycle N produces valid data in cycle N+1. Back-to-back requests give one symbol per cycle with no bubbles. `logic` paces the stream by gating symbol_iter_en.
- A pass is a sequence of length symbols followed by NUL.
- Empty buffer: the first request returns NUL immediately, and rd_ptr stays 0.
- A pass is in progress while rd_ptr!=0.
- edit_ready = (rd_ptr==0) & ~symbol_iter_en. Edits are locked out during a pass and in any cycle carrying a read request, so a pass always sees a consistent string.
- Edit commands in a cycle with edit_ready=0 are dropped, not queued. The front end must retry.
- Edit priority when edit_ready=1 and several commands are high: clear > backspace > push. Only the highest-priority command executes.
- Edit commands:
  - clear: length<=0.
  - backspace: if length>0 then length<=length-1; if length==0, ignored.
  - push: if length<BUFFER_SIZE then mem[length]<=edit_char and length<=length+1; if full, ignored with no wrap.
  - push with edit_char==0: ignored, because NUL is reserved as the terminator.
- length updates the cycle after an accepted edit.
- symbol and symbol_valid are unaffected by edits.
- Width rules:
  - length saturates at BUFFER_SIZE and never wraps.
  - rd_ptr never exceeds length.
  - The mem index is rd_ptr truncated to $clog2(BUFFER_SIZE) bits, which is safe because it is only used when rd_ptr<length.

Test Plan:
- Reset, push "x"," ","+","1", then hold iter_en for 5 cycles -> symbol_valid high for 5 cycles with symbols 'x',' ','+','1',0; length=4; rd_ptr back to 0.
- Same string, iter_en pulsed one cycle every 10 cycles -> each pulse yields exactly one valid symbol 1 cycle later, in the same order; after NUL the next pulse returns 'x'.
- Empty buffer, one iter_en pulse -> symbol=0, valid=1; length stays 0. A backspace on the empty buffer leaves length=0.
- Push 65 chars with BUFFER_SIZE=64 -> length=64 and the 65th is dropped. A full pass emits 64 symbols then NUL.
- Mid-pass (after 2 symbols), assert edit_push with 'z' -> edit_ready=0 and the push is dropped. The pass finishes unchanged; after NUL the push is accepted and length=5.
- Same-cycle edit_clear+edit_push -> length=0. Then assert rst while rd_ptr=2 -> next request starts a fresh pass, and all outputs are 0 the cycle after reset.
